// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address width and the address-phase state encoding.
// STOP_LOW/STOP_HIGH exist only when ADDR_TX_AUTO_STOP_EN is defined.
package i2c_pkg;

    localparam int I2C_ADDR_WIDTH = 7;

    typedef enum logic [3:0] {
        IDLE,
        START,
        BIT_LOW,
        BIT_HIGH,
        ACK_LOW,
        ACK_HIGH,
        DONE
`ifdef ADDR_TX_AUTO_STOP_EN
        ,
        STOP_LOW,
        STOP_HIGH
`endif
    } state_t;

endpackage

// File: rtl/address_transmitter_counter.sv
// Small up-counter with synchronous clear; saturates at all-ones instead of wrapping.
module address_transmitter_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/address_transmitter.sv
// I2C master address phase: START, 7-bit address + R/W, ACK sample.
// Optional ADDR_TX_AUTO_STOP_EN issues a STOP automatically after a NACK.
module address_transmitter
    import i2c_pkg::*;
#(
    parameter int HALF_CNT = 250
) (
    input  logic                      FPGA_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [I2C_ADDR_WIDTH-1:0] I2C_addr,
    input  logic                      rw,
    input  logic                      SDA_in,
    output logic                      SCL_out,
    output logic                      SDA_drive_low,
    output logic                      busy,
    output logic                      done,
    output logic                      ack
);

    localparam int PH_W = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_CNT - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(HALF_CNT / 2);
`ifdef ADDR_TX_AUTO_STOP_EN
    localparam logic [PH_W-1:0] PH_PRE  = PH_W'(HALF_CNT - 2);
`endif

    state_t          state_reg, state_next;
    logic [PH_W-1:0] phase_reg;
    logic [7:0]      shift_reg;
    logic            sda_low_reg;
    logic            ack_reg;
    logic [2:0]      bit_cnt;
    logic            bit_clr, bit_inc, shift_en, load;
    logic            phase_end, timed;

    assign phase_end = (phase_reg == PH_LAST);
    assign timed     = (state_reg != IDLE) && (state_reg != DONE);
    assign bit_clr   = (state_reg == IDLE);

    address_transmitter_counter #(
        .WIDTH(3)
    ) u_bit_cnt (
        .clk  (FPGA_clk),
        .srst (rst | bit_clr),
        .inc  (bit_inc),
        .count(bit_cnt)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START:    if (phase_end) state_next = BIT_LOW;
            BIT_LOW:  if (phase_end) state_next = BIT_HIGH;
            BIT_HIGH: begin
                if (phase_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = ACK_LOW;
                    end else begin
                        bit_inc    = 1'b1;
                        shift_en   = 1'b1;
                        state_next = BIT_LOW;
                    end
                end
            end
            ACK_LOW:  if (phase_end) state_next = ACK_HIGH;
            ACK_HIGH: begin
                if (phase_end) begin
`ifdef ADDR_TX_AUTO_STOP_EN
                    state_next = ack_reg ? DONE : STOP_LOW;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ADDR_TX_AUTO_STOP_EN
            STOP_LOW:  if (phase_end) state_next = STOP_HIGH;
            STOP_HIGH: if (phase_end) state_next = DONE;
`endif
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= (timed && !phase_end) ? phase_reg + 1'b1 : '0;
        end
    end

    // SDA only moves mid-way through an SCL-low half, except the START/STOP edges.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            shift_reg   <= '0;
            sda_low_reg <= 1'b0;
            ack_reg     <= 1'b0;
        end else begin
            if (load) begin
                shift_reg   <= {I2C_addr, rw};
                ack_reg     <= 1'b0;
                sda_low_reg <= 1'b1;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
            if (state_reg == BIT_LOW && phase_reg == PH_MID) begin
                sda_low_reg <= ~shift_reg[7];
            end
            if (state_reg == ACK_LOW && phase_reg == PH_MID) begin
                sda_low_reg <= 1'b0;
            end
            if (state_reg == ACK_HIGH && phase_reg == PH_MID) begin
                ack_reg <= ~SDA_in;
            end
`ifdef ADDR_TX_AUTO_STOP_EN
            if (state_reg == ACK_HIGH && phase_end && !ack_reg) begin
                sda_low_reg <= 1'b1;
            end
            if (state_reg == STOP_HIGH && phase_reg == PH_PRE) begin
                sda_low_reg <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        SCL_out = 1'b1;
        case (state_reg)
            BIT_LOW, ACK_LOW: SCL_out = 1'b0;
`ifdef ADDR_TX_AUTO_STOP_EN
            STOP_LOW:         SCL_out = 1'b0;
            // After a NACK the STOP leaves SCL high through DONE.
            DONE:             SCL_out = ~ack_reg;
`else
            DONE:             SCL_out = 1'b0;
`endif
            default:          SCL_out = 1'b1;
        endcase
    end

    assign SDA_drive_low = sda_low_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign ack           = ack_reg;

endmodule

// File: tb/tb_address_transmitter.sv
// Directed bench for address_transmitter at HALF_CNT=4; honours ADDR_TX_AUTO_STOP_EN.
module tb_address_transmitter;

    localparam int H       = 4;
    localparam int LAT     = 1 + 19 * H;
`ifdef ADDR_TX_AUTO_STOP_EN
    localparam int LAT_NAK = LAT + 2 * H;
    localparam bit STOP_EN = 1'b1;
`else
    localparam int LAT_NAK = LAT;
    localparam bit STOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] I2C_addr = '0;
    logic       rw = 1'b0;
    logic       SDA_in = 1'b1;
    logic       SCL_out, SDA_drive_low, busy, done, ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    address_transmitter #(.HALF_CNT(H)) dut (
        .FPGA_clk     (clk),
        .rst          (rst),
        .enable       (enable),
        .I2C_addr     (I2C_addr),
        .rw           (rw),
        .SDA_in       (SDA_in),
        .SCL_out      (SCL_out),
        .SDA_drive_low(SDA_drive_low),
        .busy         (busy),
        .done         (done),
        .ack          (ack)
    );

    // SDA must stay put while SCL stays high, except START (entering busy) and STOP (just before done).
    logic rst_edge = 1'b1;
    logic mon_valid = 1'b0;
    logic scl_p, sda_p, busy_p;
    bit   stop_chk = 1'b0;
    always @(posedge clk) rst_edge <= rst;
    always @(negedge clk) begin
        if (stop_chk && !done) begin
            failures++;
            $display("FAIL sda_stable: SDA released with SCL high but done=%0b, required 1", done);
        end
        stop_chk = 1'b0;
        if (mon_valid && !rst_edge && scl_p && SCL_out && (sda_p !== SDA_drive_low)) begin
            if (!sda_p && SDA_drive_low && !busy_p && busy) begin
                // START condition
            end else if (sda_p && !SDA_drive_low && busy) begin
                stop_chk = 1'b1;
            end else begin
                failures++;
                $display("FAIL sda_stable: SDA_drive_low %0b->%0b while SCL_out high, required stable",
                         sda_p, SDA_drive_low);
            end
        end
        scl_p = SCL_out; sda_p = SDA_drive_low; busy_p = busy; mon_valid = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Runs one address phase; collects the bit on each of the first 8 SCL rises.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic resp, input bit disturb,
                           input int abort_rise, output logic [7:0] bits, output int lat,
                           output bit stop_seen, output logic scl_d, output logic sda_d,
                           output bit busy_drop);
        int   rises;
        logic scl_l;
        bit   fin;
        bits = '0; lat = -1; stop_seen = 0; scl_d = 1'bx; sda_d = 1'bx; busy_drop = 0;
        rises = 0; scl_l = 1'b1; fin = 0;
        @(negedge clk);
        I2C_addr = a; rw = r; enable = 1'b1; SDA_in = ~resp;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            if (SCL_out && !scl_l) begin
                rises++;
                if (rises <= 8) bits = {bits[6:0], SDA_drive_low};
            end
            scl_l = SCL_out;
            if (rises >= 9 && !SCL_out && SDA_drive_low) stop_seen = 1;
            if (!busy) busy_drop = 1;
            SDA_in = (rises == 9 && SCL_out) ? resp : ~resp;
            if (disturb) begin
                I2C_addr = 7'($urandom);
                rw       = 1'($urandom);
                enable   = k[0];
            end
            if (done) begin
                lat = k + 1; scl_d = SCL_out; sda_d = SDA_drive_low; fin = 1; enable = 1'b0;
            end
            if (abort_rise > 0 && rises == abort_rise && !fin) begin
                rst = 1'b1;
                @(negedge clk);
                fin = 1;
            end
        end
        $display("txn addr=%02h rw=%0b resp=%0b bits=%02h lat=%0d ack=%0b stop=%0b",
                 a, r, resp, bits, lat, ack, stop_seen);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (SCL_out !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b want 1", SCL_out); end
        checks++; if (SDA_drive_low !== 1'b0) begin failures++; $display("FAIL reset_sda: got %b want 0", SDA_drive_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", ack); end
        enable = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack;
        logic [7:0] bits; int lat; bit st, bd; logic sc, sd;
        run_txn(7'h5A, 1'b0, 1'b0, 0, 0, bits, lat, st, sc, sd, bd);
        checks++; if (bits !== 8'h4B) begin failures++; $display("FAIL ack_bits: got %02h want 4b", bits); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL ack_latency: got %0d want %0d", lat, LAT); end
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ack_value: got %b want 1", ack); end
        checks++; if (sc !== 1'b0) begin failures++; $display("FAIL ack_done_scl: got %b want 0", sc); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL ack_busy_drop: got %b want 0", bd); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ack_done_pulse: done=%b busy=%b want 0 0", done, busy); end
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ack_hold: got %b want 1", ack); end
    endtask

    task automatic test_nack;
        logic [7:0] bits; int lat; bit st, bd; logic sc, sd;
        run_txn(7'h5A, 1'b0, 1'b1, 0, 0, bits, lat, st, sc, sd, bd);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL nack_value: got %b want 0", ack); end
        checks++; if (lat !== LAT_NAK) begin failures++; $display("FAIL nack_latency: got %0d want %0d", lat, LAT_NAK); end
        checks++; if (st !== STOP_EN) begin failures++; $display("FAIL nack_stop: got %b want %b", st, STOP_EN); end
        checks++; if (sc !== STOP_EN) begin failures++; $display("FAIL nack_done_scl: got %b want %b", sc, STOP_EN); end
        checks++; if (sd !== 1'b0) begin failures++; $display("FAIL nack_done_sda: got %b want 0", sd); end
        @(negedge clk);
    endtask

    task automatic test_read;
        logic [7:0] bits; int lat; bit st, bd; logic sc, sd;
        run_txn(7'h33, 1'b1, 1'b0, 0, 0, bits, lat, st, sc, sd, bd);
        checks++; if (bits !== 8'h98) begin failures++; $display("FAIL read_bits: got %02h want 98", bits); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL read_latency: got %0d want %0d", lat, LAT); end
        run_txn(7'h7F, 1'b0, 1'b0, 0, 0, bits, lat, st, sc, sd, bd);
        checks++; if (bits !== 8'h01) begin failures++; $display("FAIL ones_bits: got %02h want 01", bits); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] bits; int lat; bit st, bd; logic sc, sd; int dcnt;
        run_txn(7'h5A, 1'b0, 1'b0, 0, 4, bits, lat, st, sc, sd, bd);
        checks++; if (SCL_out !== 1'b1 || SDA_drive_low !== 1'b0) begin failures++; $display("FAIL midrst_bus: scl=%b sda=%b want 1 0", SCL_out, SDA_drive_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (lat !== -1) begin failures++; $display("FAIL midrst_early_done: lat=%0d want none", lat); end
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL midrst_silent: activity=%0d want 0", dcnt); end
        run_txn(7'h5A, 1'b0, 1'b0, 0, 0, bits, lat, st, sc, sd, bd);
        checks++; if (bits !== 8'h4B) begin failures++; $display("FAIL midrst_clean_bits: got %02h want 4b", bits); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL midrst_clean_latency: got %0d want %0d", lat, LAT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ndone, gap1, gap2, period, last_done, gap;
        bit counting;
        ndone = 0; gap1 = -1; gap2 = -1; period = -1; last_done = -1; gap = 0; counting = 0;
        SDA_in = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 400 && ndone < 3; k++) begin
            @(negedge clk);
            if (counting) begin
                if (!busy) gap++;
                else begin
                    if (ndone == 1) gap1 = gap; else gap2 = gap;
                    counting = 0;
                end
            end
            if (done) begin
                ndone++;
                if (last_done >= 0) period = k - last_done;
                last_done = k; gap = 0; counting = 1;
            end
        end
        enable = 1'b0;
        repeat (100) @(negedge clk);
        $display("back_to_back gap1=%0d gap2=%0d period=%0d", gap1, gap2, period);
        checks++; if (gap1 !== 1) begin failures++; $display("FAIL b2b_gap1: got %0d want 1", gap1); end
        checks++; if (gap2 !== 1) begin failures++; $display("FAIL b2b_gap2: got %0d want 1", gap2); end
        checks++; if (period !== LAT + 1) begin failures++; $display("FAIL b2b_period: got %0d want %0d", period, LAT + 1); end
    endtask

    task automatic test_capture;
        logic [7:0] bits; int lat; bit st, bd; logic sc, sd; int act;
        run_txn(7'h5A, 1'b0, 1'b0, 1, 0, bits, lat, st, sc, sd, bd);
        checks++; if (bits !== 8'h4B) begin failures++; $display("FAIL capture_bits: got %02h want 4b", bits); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL capture_latency: got %0d want %0d", lat, LAT); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL capture_restart: busy dropped=%b want 0", bd); end
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) act++;
        end
        checks++; if (act !== 0) begin failures++; $display("FAIL capture_idle_after: busy cycles=%0d want 0", act); end
    endtask

    initial begin
        test_reset;
        test_ack;
        test_nack;
        test_read;
        test_reset_mid;
        test_back_to_back;
        test_capture;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
